pc_unit: RTL and testbench

Parameterised program-counter unit for the fetch stage, successor to the fixed-width PC register. It holds the fetch address and selects the next one from sequential increment, branch/jump redirect, or trap vector. It also supports stall, halt/resume, misaligned-target detection and exception-PC capture. Its outputs drive the instruction-memory address and the `pc + INSTR_BYTES` value used by the link/branch logic.

---
 rtl/pc_unit.sv | 114 +++++++++++
 tb/tb_pc_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential increment, redirect, trap vectoring, stall and halt/resume.
// Define PC_MISALIGN_TRAP_EN to turn misaligned redirects into traps; otherwise the low bits are dropped.
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int              INSTR_BYTES  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap,
   input  logic            halt,
   input  logic            resume,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus,
   output logic            pc_valid,
   output logic [XLEN-1:0] epc,
   output logic            misalign_trap
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] redirect_pc;

`ifdef PC_MISALIGN_TRAP_EN
   logic redirect_misaligned;
   assign redirect_misaligned = (redirect_target & ALIGN_MASK) != '0;
   assign redirect_pc         = redirect_target;
`else
   // Without trapping, a misaligned target is silently rounded down to an instruction boundary.
   assign redirect_pc = redirect_target & ~ALIGN_MASK;
`endif

   assign pc_plus = pc_q + XLEN'(INSTR_BYTES);

   // NOTE: every variable gets its hold/default value first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      misalign_d = 1'b0;

      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (trap) begin
               pc_d  = TRAP_VECTOR;
               epc_d = pc_q;
`ifdef PC_MISALIGN_TRAP_EN
            end else if (redirect && redirect_misaligned) begin
               pc_d       = TRAP_VECTOR;
               epc_d      = redirect_target;
               misalign_d = 1'b1;
`endif
            end else if (redirect) begin
               pc_d = redirect_pc;
            end else if (halt) begin
               state_d = HALT;
            end else if (!stall) begin
               pc_d = pc_plus;
            end
         end
         HALT: begin
            // Redirect and stall are meaningless while halted; only trap or a clean resume wake the unit.
            if (trap) begin
               pc_d    = TRAP_VECTOR;
               epc_d   = pc_q;
               state_d = RUN;
            end else if (resume && !halt) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc            = pc_q;
   assign pc_valid      = (state_q == RUN);
   assign epc           = epc_q;
   assign misalign_trap = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations, then random
// stimulus against a behavioural reference model of the next-PC rules.
module tb_pc_unit;

`ifdef PC_MISALIGN_TRAP_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, stall, redirect, trap, halt, resume;
   logic [31:0] redirect_target;
   logic [31:0] pc, pc_plus, epc;
   logic        pc_valid, misalign_trap;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state.
   logic [31:0] m_pc, m_epc;
   bit          m_boot, m_halt, m_mis;

   pc_unit dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .trap            (trap),
      .halt            (halt),
      .resume          (resume),
      .pc              (pc),
      .pc_plus         (pc_plus),
      .pc_valid        (pc_valid),
      .epc             (epc),
      .misalign_trap   (misalign_trap)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      bit misaligned;
      misaligned = (redirect_target % 4) != 0;
      m_mis = 1'b0;
      if (reset) begin
         m_pc   = 32'h0;
         m_epc  = 32'h0;
         m_boot = 1'b1;
         m_halt = 1'b0;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_halt) begin
         if (trap) begin
            m_epc  = m_pc;
            m_pc   = 32'h100;
            m_halt = 1'b0;
         end else if (resume && !halt) begin
            m_halt = 1'b0;
         end
      end else begin
         if (trap) begin
            m_epc = m_pc;
            m_pc  = 32'h100;
         end else if (redirect && misaligned && MIS_EN) begin
            m_epc = redirect_target;
            m_pc  = 32'h100;
            m_mis = 1'b1;
         end else if (redirect) begin
            m_pc = redirect_target - (redirect_target % 4);
         end else if (halt) begin
            m_halt = 1'b1;
         end else if (!stall) begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_target = 32'h0;
      trap            = 1'b0;
      halt            = 1'b0;
      resume          = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
      n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
      n_cmp++; if (epc !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h expected 0", epc); end
      n_cmp++; if (misalign_trap !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b expected 0", misalign_trap); end
      reset = 1'b0;
      n_cmp++; if (pc_valid !== 1'b0 || pc !== 32'h0) begin
         n_err++; $display("FAIL boot_cycle: got pc=%h valid=%b expected pc=0 valid=0", pc, pc_valid);
      end
   endtask

   task automatic test_free_run();
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (pc !== 32'(4 * i) || pc_plus !== 32'(4 * i + 4) || pc_valid !== 1'b1) begin
            n_err++;
            $display("FAIL free_run[%0d]: got pc=%h plus=%h valid=%b expected pc=%h plus=%h valid=1",
                     i, pc, pc_plus, pc_valid, 32'(4 * i), 32'(4 * i + 4));
         end
      end
   endtask

   task automatic test_stall();
      redirect = 1'b1; redirect_target = 32'h8;
      tick();
      redirect = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL stall_hold[%0d]: got %h expected 8", i, pc); end
      end
      redirect = 1'b1; redirect_target = 32'h40;
      tick();
      n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL redirect_over_stall: got %h expected 40", pc); end
      idle();
   endtask

   task automatic test_trap_redirect();
      redirect = 1'b1; redirect_target = 32'h20;
      tick();
      trap = 1'b1; redirect_target = 32'h80;
      tick();
      n_cmp++; if (pc !== 32'h100 || epc !== 32'h20 || misalign_trap !== 1'b0) begin
         n_err++; $display("FAIL trap_over_redirect: got pc=%h epc=%h mis=%b expected pc=100 epc=20 mis=0", pc, epc, misalign_trap);
      end
      idle();
      tick();
      n_cmp++; if (pc !== 32'h104 || epc !== 32'h20) begin
         n_err++; $display("FAIL after_trap: got pc=%h epc=%h expected pc=104 epc=20", pc, epc);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] e_pc, e_epc, e_pc2;
      logic        e_mis;
      e_pc  = MIS_EN ? 32'h100 : 32'h40;
      e_epc = MIS_EN ? 32'h42  : 32'h20;
      e_mis = MIS_EN;
      e_pc2 = e_pc + 32'd4;
      redirect = 1'b1; redirect_target = 32'h42;
      tick();
      n_cmp++; if (pc !== e_pc || epc !== e_epc || misalign_trap !== e_mis) begin
         n_err++; $display("FAIL misalign_redirect: got pc=%h epc=%h mis=%b expected pc=%h epc=%h mis=%b",
                           pc, epc, misalign_trap, e_pc, e_epc, e_mis);
      end
      idle();
      tick();
      n_cmp++; if (pc !== e_pc2 || epc !== e_epc || misalign_trap !== 1'b0) begin
         n_err++; $display("FAIL misalign_pulse_end: got pc=%h epc=%h mis=%b expected pc=%h epc=%h mis=0",
                           pc, epc, misalign_trap, e_pc2, e_epc);
      end
   endtask

   task automatic test_halt();
      redirect = 1'b1; redirect_target = 32'h10;
      tick();
      redirect = 1'b0; halt = 1'b1;
      tick();
      halt = 1'b0;
      n_cmp++; if (pc !== 32'h10 || pc_valid !== 1'b0) begin
         n_err++; $display("FAIL halt_enter: got pc=%h valid=%b expected pc=10 valid=0", pc, pc_valid);
      end
      for (int i = 0; i < 5; i++) begin
         stall = i[0]; redirect = !i[0]; redirect_target = 32'h200;
         tick();
         n_cmp++; if (pc !== 32'h10 || pc_valid !== 1'b0) begin
            n_err++; $display("FAIL halt_hold[%0d]: got pc=%h valid=%b expected pc=10 valid=0", i, pc, pc_valid);
         end
      end
      idle();
      halt = 1'b1; resume = 1'b1;
      tick();
      n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL halt_resume_both: got valid=%b expected 0", pc_valid); end
      halt = 1'b0;
      tick();
      n_cmp++; if (pc !== 32'h10 || pc_valid !== 1'b1) begin
         n_err++; $display("FAIL resume: got pc=%h valid=%b expected pc=10 valid=1", pc, pc_valid);
      end
      idle();
      tick();
      n_cmp++; if (pc !== 32'h14) begin n_err++; $display("FAIL resume_next: got %h expected 14", pc); end
      halt = 1'b1;
      tick();
      halt = 1'b0; trap = 1'b1;
      tick();
      n_cmp++; if (pc !== 32'h100 || epc !== 32'h14 || pc_valid !== 1'b1) begin
         n_err++; $display("FAIL trap_in_halt: got pc=%h epc=%h valid=%b expected pc=100 epc=14 valid=1", pc, epc, pc_valid);
      end
      idle();
   endtask

   task automatic test_wrap_and_reset();
      redirect = 1'b1; redirect_target = 32'hFFFF_FFF8;
      tick();
      idle();
      n_cmp++; if (pc !== 32'hFFFF_FFF8 || pc_plus !== 32'hFFFF_FFFC) begin
         n_err++; $display("FAIL wrap0: got pc=%h plus=%h expected pc=fffffff8 plus=fffffffc", pc, pc_plus);
      end
      tick();
      n_cmp++; if (pc !== 32'hFFFF_FFFC || pc_plus !== 32'h0) begin
         n_err++; $display("FAIL wrap1: got pc=%h plus=%h expected pc=fffffffc plus=0", pc, pc_plus);
      end
      tick();
      n_cmp++; if (pc !== 32'h0 || pc_plus !== 32'h4 || misalign_trap !== 1'b0) begin
         n_err++; $display("FAIL wrap2: got pc=%h plus=%h mis=%b expected pc=0 plus=4 mis=0", pc, pc_plus, misalign_trap);
      end
      tick();
      reset = 1'b1; trap = 1'b1; redirect = 1'b1; redirect_target = 32'h80; stall = 1'b1;
      tick();
      n_cmp++; if (pc !== 32'h0 || pc_valid !== 1'b0 || epc !== 32'h0) begin
         n_err++; $display("FAIL mid_reset: got pc=%h valid=%b epc=%h expected pc=0 valid=0 epc=0", pc, pc_valid, epc);
      end
      reset = 1'b0;
      idle();
      tick();
      n_cmp++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin
         n_err++; $display("FAIL mid_reset_boot: got pc=%h valid=%b expected pc=0 valid=1", pc, pc_valid);
      end
   endtask

   task automatic test_random();
      logic [31:0] e_plus;
      logic        e_valid;
      for (int i = 0; i < 500; i++) begin
         reset           = ($urandom_range(63) == 0);
         trap            = ($urandom_range(15) == 0);
         redirect        = ($urandom_range(3) == 0);
         redirect_target = $urandom();
         if ($urandom_range(1) == 0) redirect_target[1:0] = 2'b00;
         halt            = ($urandom_range(11) == 0);
         resume          = ($urandom_range(3) == 0);
         stall           = ($urandom_range(3) == 0);
         tick();
         e_plus  = m_pc + 32'd4;
         e_valid = !m_boot && !m_halt;
         n_cmp++; if (pc !== m_pc || pc_plus !== e_plus || pc_valid !== e_valid) begin
            n_err++; $display("FAIL rand_pc[%0d]: got pc=%h plus=%h valid=%b expected pc=%h plus=%h valid=%b",
                              i, pc, pc_plus, pc_valid, m_pc, e_plus, e_valid);
         end
         n_cmp++; if (epc !== m_epc || misalign_trap !== m_mis) begin
            n_err++; $display("FAIL rand_epc[%0d]: got epc=%h mis=%b expected epc=%h mis=%b",
                              i, epc, misalign_trap, m_epc, m_mis);
         end
      end
      reset = 1'b0;
      idle();
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_trap_redirect();
      test_misalign();
      test_halt();
      test_wrap_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
